// File: rtl/div_16_8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_16_8_seq
//  Description : Sequential signed divider (DW_A-bit dividend / DW_B-bit
//                divisor). It uses radix-2 restoring division over operand
//                magnitudes, producing one quotient bit per clock, and then
//                applies a sign fix-up. The quotient is truncated toward zero,
//                and the remainder takes the sign of the dividend.
//                Valid/ready handshakes are used on both the input and the
//                output side.
//  Ports       : sys_clk, sys_rst_n (async, active-low)
//                in_valid/in_ready   - operand handshake
//                dividend, divisor   - signed operands, sampled on accept
//                out_valid/out_ready - result handshake
//                quotient, remainder - signed results, held until taken
//                div_zero            - result came from a zero divisor
//  Revision    : 1.0 - initial release
// ============================================================================
module div_16_8_seq #(
    parameter int DW_A = 16,
    parameter int DW_B = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW_A-1:0] dividend,
    input  logic signed [DW_B-1:0] divisor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [DW_A-1:0] quotient,
    output logic signed [DW_B-1:0] remainder,
    output logic                   div_zero
);

    localparam int                c_CNT_W = $clog2(DW_A + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DW_A - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Magnitudes are stored as unsigned values. An unsigned DW_A-bit field
    // holds 2^(DW_A-1), so both |-2^(DW_A-1)| and the quotient magnitude of
    // -2^(DW_A-1) / -1 are represented exactly. Taking the low DW_A bits at
    // the sign fix-up stage gives the wrap-around result.
    logic [DW_A-1:0]    r_dq;       // dividend bits shift out, quotient bits shift in
    logic [DW_B-1:0]    r_dsr;      // |divisor|
    logic [DW_B-1:0]    r_rem;      // partial remainder, always < |divisor|
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sq;
    logic               r_sr;
    logic               r_dz;
    logic [DW_A-1:0]    r_quot;
    logic [DW_B-1:0]    r_remo;
    logic               r_divz;

    logic [DW_A-1:0]    w_dvd_abs;
    logic [DW_B-1:0]    w_dsr_abs;
    logic [DW_B:0]      w_shift;
    logic               w_ge;
    logic [DW_B-1:0]    w_rem_nxt;
    logic               w_last;

    assign w_dvd_abs = dividend[DW_A-1] ? DW_A'(-dividend) : DW_A'(dividend);
    assign w_dsr_abs = divisor[DW_B-1]  ? DW_B'(-divisor)  : DW_B'(divisor);

    // Restoring step. The partial remainder is shifted left, and the next
    // dividend bit enters at the LSB. This (DW_B+1)-bit value is then compared
    // against |divisor|. Either result is below |divisor|, so it fits in
    // DW_B bits again.
    assign w_shift   = {r_rem, r_dq[DW_A-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dsr});
    assign w_rem_nxt = DW_B'(w_ge ? (w_shift - {1'b0, r_dsr}) : w_shift);
    assign w_last    = (r_cnt == c_LAST);

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dq   <= '0;
            r_dsr  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_sq   <= 1'b0;
            r_sr   <= 1'b0;
            r_dz   <= 1'b0;
            r_quot <= '0;
            r_remo <= '0;
            r_divz <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_dq  <= w_dvd_abs;
                        r_dsr <= w_dsr_abs;
                        r_rem <= '0;
                        r_cnt <= '0;
                        r_sq  <= dividend[DW_A-1] ^ divisor[DW_B-1];
                        r_sr  <= dividend[DW_A-1];
                        r_dz  <= (divisor == '0);
                    end
                end
                S_CALC: begin
                    r_dq  <= {r_dq[DW_A-2:0], w_ge};
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                S_FIX: begin
                    // A zero divisor still runs the full iteration count, which
                    // keeps latency fixed. Its results are forced afterwards.
                    if (r_dz) begin
                        r_quot <= '1;
                        r_remo <= '0;
                    end else begin
                        r_quot <= r_sq ? (DW_A'(0) - r_dq)  : r_dq;
                        r_remo <= r_sr ? (DW_B'(0) - r_rem) : r_rem;
                    end
                    r_divz <= r_dz;
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_remo;
    assign div_zero  = r_divz;

endmodule
`default_nettype wire

// File: tb/tb_div_16_8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_16_8_seq
//  Description : Directed self-checking bench for div_16_8_seq. It covers
//                reset values, sign combinations, edge operands, division by
//                zero, output backpressure, reset during iteration, and a
//                multiply/divide round trip.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_16_8_seq;

    localparam int DW_A = 16;
    localparam int DW_B = 8;

    logic                   sys_clk;
    logic                   sys_rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [DW_A-1:0] dividend;
    logic signed [DW_B-1:0] divisor;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [DW_A-1:0] quotient;
    logic signed [DW_B-1:0] remainder;
    logic                   div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    div_16_8_seq #(.DW_A(DW_A), .DW_B(DW_B)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one operation. It starts and ends on a falling edge. lat counts
    // rising edges from the accepting edge until out_valid is seen.
    task automatic do_op(input logic signed [15:0] a, input logic signed [7:0] b,
                         input int in_gap, input int out_gap,
                         output logic signed [15:0] q, output logic signed [7:0] r,
                         output logic dz, output int lat, output bit ok);
        int w;
        ok  = 1'b1;
        lat = 0;
        w   = 0;
        repeat (in_gap) @(negedge sys_clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 100) begin
            @(negedge sys_clk);
            w++;
        end
        if (!in_ready) ok = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        in_valid = 1'b0;
        dividend = 16'sh5A5A;
        divisor  = 8'sh33;
        while (!out_valid && lat < 40) begin
            @(posedge sys_clk);
            lat++;
            @(negedge sys_clk);
        end
        if (!out_valid) ok = 1'b0;
        repeat (out_gap) @(negedge sys_clk);
        q = quotient;
        r = remainder;
        dz = div_zero;
        out_ready = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        if (quotient !== 16'sd0) begin n_fail++; $display("FAIL reset quotient: got %0d want 0", quotient); end
        if (remainder !== 8'sd0) begin n_fail++; $display("FAIL reset remainder: got %0d want 0", remainder); end
        if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset div_zero: got %b want 0", div_zero); end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_signs();
        int ta[4] = '{1000, -1000, 1000, -1000};
        int tb[4] = '{7, 7, -7, -7};
        int eq[4] = '{142, -142, -142, 142};
        int er[4] = '{6, -6, 6, -6};
        logic signed [15:0] q;
        logic signed [7:0]  r;
        logic dz;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(16'(ta[i]), 8'(tb[i]), 0, 0, q, r, dz, lat, ok);
            n_checks += 5;
            if (!ok) begin n_fail++; $display("FAIL signs[%0d] handshake: timed out", i); end
            if (q !== 16'(eq[i])) begin n_fail++; $display("FAIL signs[%0d] quotient: got %0d want %0d", i, q, eq[i]); end
            if (r !== 8'(er[i])) begin n_fail++; $display("FAIL signs[%0d] remainder: got %0d want %0d", i, r, er[i]); end
            if (dz !== 1'b0) begin n_fail++; $display("FAIL signs[%0d] div_zero: got %b want 0", i, dz); end
            if (lat != 17) begin n_fail++; $display("FAIL signs[%0d] latency: got %0d want 17", i, lat); end
        end
    endtask

    task automatic test_edges();
        int ta[4] = '{-32768, -32768, 32767, 0};
        int tb[4] = '{-1, -128, -128, -5};
        int eq[4] = '{-32768, 256, -255, 0};
        int er[4] = '{0, 0, 127, 0};
        logic signed [15:0] q;
        logic signed [7:0]  r;
        logic dz;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(16'(ta[i]), 8'(tb[i]), 1, 0, q, r, dz, lat, ok);
            n_checks += 4;
            if (!ok) begin n_fail++; $display("FAIL edges[%0d] handshake: timed out", i); end
            if (q !== 16'(eq[i])) begin n_fail++; $display("FAIL edges[%0d] quotient: got %0d want %0d", i, q, eq[i]); end
            if (r !== 8'(er[i])) begin n_fail++; $display("FAIL edges[%0d] remainder: got %0d want %0d", i, r, er[i]); end
            if (dz !== 1'b0) begin n_fail++; $display("FAIL edges[%0d] div_zero: got %b want 0", i, dz); end
        end
    endtask

    task automatic test_div_zero();
        logic signed [15:0] q;
        logic signed [7:0]  r;
        logic dz;
        int lat;
        bit ok;
        do_op(16'sd1234, 8'sd0, 0, 0, q, r, dz, lat, ok);
        n_checks += 5;
        if (!ok) begin n_fail++; $display("FAIL divzero handshake: timed out"); end
        if (q !== 16'hFFFF) begin n_fail++; $display("FAIL divzero quotient: got %h want ffff", q); end
        if (r !== 8'sd0) begin n_fail++; $display("FAIL divzero remainder: got %0d want 0", r); end
        if (dz !== 1'b1) begin n_fail++; $display("FAIL divzero div_zero: got %b want 1", dz); end
        if (lat != 17) begin n_fail++; $display("FAIL divzero latency: got %0d want 17", lat); end
        do_op(16'sd10, 8'sd3, 0, 0, q, r, dz, lat, ok);
        n_checks += 4;
        if (!ok) begin n_fail++; $display("FAIL after_divzero handshake: timed out"); end
        if (q !== 16'sd3) begin n_fail++; $display("FAIL after_divzero quotient: got %0d want 3", q); end
        if (r !== 8'sd1) begin n_fail++; $display("FAIL after_divzero remainder: got %0d want 1", r); end
        if (dz !== 1'b0) begin n_fail++; $display("FAIL after_divzero div_zero: got %b want 0", dz); end
    endtask

    task automatic test_backpressure();
        int w;
        int lat;
        int bad;
        // Operation 500/-7 = -71 remainder 3; the pending op 77/5 = 15 remainder 2.
        dividend = 16'sd500;
        divisor  = -8'sd7;
        in_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        dividend = 16'sd77;
        divisor  = 8'sd5;
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge sys_clk);
            w++;
        end
        n_checks++;
        if (!out_valid) begin n_fail++; $display("FAIL backpressure first result: timed out"); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== -16'sd71 ||
                remainder !== 8'sd3 || div_zero !== 1'b0) begin
                bad++;
                $display("FAIL backpressure hold cycle %0d: got v=%b rdy=%b q=%0d r=%0d want v=1 rdy=0 q=-71 r=3",
                         i, out_valid, in_ready, quotient, remainder);
            end
            @(negedge sys_clk);
        end
        n_checks++;
        if (bad != 0) n_fail++;
        out_ready = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure idle in_ready: got %b want 1", in_ready); end
        @(posedge sys_clk);
        @(negedge sys_clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge sys_clk);
            lat++;
            @(negedge sys_clk);
        end
        n_checks += 3;
        if (lat != 17) begin n_fail++; $display("FAIL backpressure pending latency: got %0d want 17", lat); end
        if (quotient !== 16'sd15) begin n_fail++; $display("FAIL backpressure pending quotient: got %0d want 15", quotient); end
        if (remainder !== 8'sd2) begin n_fail++; $display("FAIL backpressure pending remainder: got %0d want 2", remainder); end
        out_ready = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        logic signed [15:0] q;
        logic signed [7:0]  r;
        logic dz;
        int lat;
        bit ok;
        bit seen;
        // The outputs still hold 15/2 from the previous operation.
        dividend = 16'sd100;
        divisor  = 8'sd9;
        in_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        in_valid = 1'b0;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset out_valid: got %b want 0", out_valid); end
        if (quotient !== 16'sd0) begin n_fail++; $display("FAIL midreset quotient: got %0d want 0", quotient); end
        if (remainder !== 8'sd0) begin n_fail++; $display("FAIL midreset remainder: got %0d want 0", remainder); end
        if (div_zero !== 1'b0) begin n_fail++; $display("FAIL midreset div_zero: got %b want 0", div_zero); end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge sys_clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midreset stray out_valid: got 1 want 0"); end
        do_op(16'sd100, 8'sd9, 0, 0, q, r, dz, lat, ok);
        n_checks += 4;
        if (!ok) begin n_fail++; $display("FAIL midreset recovery handshake: timed out"); end
        if (q !== 16'sd11) begin n_fail++; $display("FAIL midreset recovery quotient: got %0d want 11", q); end
        if (r !== 8'sd1) begin n_fail++; $display("FAIL midreset recovery remainder: got %0d want 1", r); end
        if (lat != 17) begin n_fail++; $display("FAIL midreset recovery latency: got %0d want 17", lat); end
    endtask

    task automatic test_round_trip();
        int bs[12] = '{1, -1, 2, -2, 3, 7, -13, 64, -64, 127, -128, -100};
        logic signed [15:0] q;
        logic signed [7:0]  r;
        logic signed [15:0] prod;
        logic dz;
        int lat;
        bit ok;
        for (int a = -128; a <= 127; a += 5) begin
            for (int j = 0; j < 12; j++) begin
                prod = 16'(a * bs[j]);
                do_op(prod, 8'(bs[j]), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      q, r, dz, lat, ok);
                n_checks++;
                if (!ok || q !== 16'(a) || r !== 8'sd0 || dz !== 1'b0) begin
                    n_fail++;
                    $display("FAIL roundtrip %0d*%0d/%0d: got q=%0d r=%0d dz=%b ok=%b want q=%0d r=0 dz=0",
                             a, bs[j], bs[j], q, r, dz, ok, a);
                end
            end
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        test_reset();
        test_signs();
        test_edges();
        test_div_zero();
        test_backpressure();
        test_reset_mid_calc();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
